spi_bus_arbiter: RTL
====================

// Module: spi_bus_arbiter
// PURPOSE
//  Shares one spi_master instance between NUM_REQ requesters and sequences multi-byte SPI transactions.
//  Each transaction runs: chip-select setup -> N byte transfers -> chip-select hold.
//  Grants are round-robin; each requester drives its own active-low chip select.
//  Sits between the SPI clients (CPU I/O, peripherals) and spi_master; wraps spi_master's start/busy/valid handshake.
// PARAMETERS
//  DATA_WIDTH  8  byte width; must match spi_master DATA_WIDTH
//  NUM_REQ     2  number of requesters / slaves (>=2)
//  LEN_WIDTH   4  width of per-requester byte-count field
//  CS_SETUP    2  clk cycles from cs_n fall to first spi_start (>=1)
//  CS_HOLD     2  clk cycles from last spi_valid to cs_n rise (>=1)
// PORTS
//  clk         in   1                     system clock
//  rst         in   1                     reset: synchronous, active-high
//  req         in   NUM_REQ               level request per requester
//  req_len     in   NUM_REQ*LEN_WIDTH     byte count per requester, slice i; sampled at grant
//  tx_data     in   NUM_REQ*DATA_WIDTH    next byte per requester, slice i
//  grant       out  NUM_REQ               one-hot owner of the bus; 0 when idle
//  tx_ready    out  NUM_REQ               1-cycle pulse: tx_data slice consumed
//  rx_data     out  DATA_WIDTH            last received byte
//  rx_valid    out  NUM_REQ               1-cycle one-hot pulse: rx_data valid for that requester
//  done        out  NUM_REQ               1-cycle pulse: transaction finished, cs_n released
//  cs_n        out  NUM_REQ               active-low chip selects
//  spi_start   out  1                     to spi_master.start
//  spi_data_in out  DATA_WIDTH            to spi_master.data_in
//  spi_busy    in   1                     from spi_master.busy
//  spi_data_out in  DATA_WIDTH            from spi_master.data_out
//  spi_valid   in   1                     from spi_master.valid_data
// BEHAVIOUR
//  Reset: grant=0, tx_ready=0, rx_valid=0, done=0, spi_start=0, spi_data_in=0, rx_data=0.
//   cs_n all 1s; state=IDLE; rr pointer=0, so requester 0 has first priority.
//  Reset mid-transaction aborts immediately: cs_n rises on the next edge; no done pulse.
//  All outputs are registered.
//  FSM: IDLE -> SETUP -> START -> WAIT -> (START | HOLD) -> IDLE.
//  IDLE:
//   - If any req bit is set, pick the first set bit at or after ptr, modulo NUM_REQ.
//   - Set grant to that one-hot, drive its cs_n low.
//   - Latch rem = req_len slice; rem=0 is treated as 1.
//   - Load cnt = CS_SETUP, go to SETUP. Requests are not evaluated elsewhere.
//  SETUP: decrement cnt; when cnt reaches 1 -> START.
//   cs_n is therefore low for exactly CS_SETUP cycles before spi_start.
//  START:
//   - If spi_busy=1, stay.
//   - Else, for one cycle: spi_start=1, spi_data_in = tx_data slice of granted requester, tx_ready[g]=1.
//   - Go to WAIT.
//  WAIT:
//   - On spi_valid: rx_data <= spi_data_out, rx_valid[g]=1 for one cycle, rem <= rem-1.
//   - If rem was 1: load cnt=CS_HOLD, go to HOLD. Else go to START.
//   - Back-to-back bytes: minimum one cycle between spi_valid and the next spi_start.
//  HOLD:
//   - Decrement cnt; on expiry raise cs_n, clear grant, pulse done[g].
//   - Set ptr = (g+1) mod NUM_REQ; go to IDLE.
//   - A new grant cannot come earlier than the cycle after done.
//  Boundary cases:
//   - spi_valid outside WAIT is ignored.
//   - req dropping during a transaction is ignored; the latched length always completes.
//   - req_len / tx_data changes after sampling do not affect rem.
//   - tx_data is sampled only in the START cycle.
//   - Simultaneous requests resolve strictly by the rr pointer.
//   - A requester holding req continuously regains the bus only after every other active requester has had one grant.
//   - At most one cs_n bit is low at any time; grant==~cs_n at all times.
// TESTING
//  T1 reset: rst=1 for 3 cycles mid-WAIT -> cs_n=2'b11, grant=0, no done, spi_start=0 next cycle.
//  T2 single: req=01, len0=3, tx_data0=A5 -> cs_n[0] low 2 cycles before 1st spi_start; 3 starts, 3 rx_valid[0]; cs_n rises 2 cycles after 3rd valid; done[0] pulse.
//  T3 round-robin: req=11 held, len=1 each -> grants alternate 01,10,01,10; each grant separated by >=1 idle cycle.
//  T4 len=0: req=10, len1=0 -> exactly one byte transferred, done[1] pulses.
//  T5 busy stall: spi_busy forced 1 for 10 cycles in START -> spi_start stays 0; asserts one cycle after busy falls.
//  T6 loopback: miso tied to mosi, len0=2, bytes 3C,C3 -> rx_data 3C then C3 with rx_valid[0]; stray spi_valid in IDLE -> no rx_valid.

Source files
------------

// File: rtl/spi_bus_arbiter_if.sv
// spi_bus_arbiter_if: requester-side and spi_master-side signals of the SPI bus arbiter.
interface spi_bus_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2,
    parameter int LEN_WIDTH  = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
    logic [NUM_REQ*DATA_WIDTH-1:0] tx_data;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            tx_ready;
    logic [DATA_WIDTH-1:0]         rx_data;
    logic [NUM_REQ-1:0]            rx_valid;
    logic [NUM_REQ-1:0]            done;
    logic [NUM_REQ-1:0]            cs_n;
    logic                          spi_start;
    logic [DATA_WIDTH-1:0]         spi_data_in;
    logic                          spi_busy;
    logic [DATA_WIDTH-1:0]         spi_data_out;
    logic                          spi_valid;

    modport master (
        input  req, req_len, tx_data, spi_busy, spi_data_out, spi_valid,
        output grant, tx_ready, rx_data, rx_valid, done, cs_n, spi_start, spi_data_in
    );

    modport slave (
        output req, req_len, tx_data, spi_busy, spi_data_out, spi_valid,
        input  grant, tx_ready, rx_data, rx_valid, done, cs_n, spi_start, spi_data_in
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one spi_master among NUM_REQ requesters,
// framing each multi-byte transaction with chip-select setup and hold intervals.
module spi_bus_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2,
    parameter int LEN_WIDTH  = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2
) (
    input logic clk,
    input logic rst,
    spi_bus_arbiter_if.master bus
);
    localparam int IW   = $clog2(NUM_REQ);
    localparam int CMAX = CS_SETUP > CS_HOLD ? CS_SETUP : CS_HOLD;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, HOLD} state_t;

    state_t               state;
    logic [IW-1:0]        ptr, g, pick;
    logic                 hit;
    logic [LEN_WIDTH-1:0] rem, len;
    logic [CW-1:0]        cnt;
    int                   j;

    // Scan from the highest offset down so the nearest set bit at/after ptr wins.
    always_comb begin
        pick = '0;
        hit  = 1'b0;
        j    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (bus.req[IW'(j)]) begin
                pick = IW'(j);
                hit  = 1'b1;
            end
        end
    end

    assign len = bus.req_len[pick*LEN_WIDTH +: LEN_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= '0;
            g               <= '0;
            rem             <= '0;
            cnt             <= '0;
            bus.grant       <= '0;
            bus.cs_n        <= '1;
            bus.tx_ready    <= '0;
            bus.rx_valid    <= '0;
            bus.done        <= '0;
            bus.spi_start   <= 1'b0;
            bus.spi_data_in <= '0;
            bus.rx_data     <= '0;
        end else begin
            bus.spi_start <= 1'b0;
            bus.tx_ready  <= '0;
            bus.rx_valid  <= '0;
            bus.done      <= '0;
            case (state)
                IDLE: if (hit) begin
                    g         <= pick;
                    bus.grant <= NUM_REQ'(1) << pick;
                    bus.cs_n  <= ~(NUM_REQ'(1) << pick);
                    rem       <= len == '0 ? LEN_WIDTH'(1) : len;
                    cnt       <= CW'(CS_SETUP - 1);
                    state     <= CS_SETUP == 1 ? START : SETUP;
                end
                SETUP: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= START;
                end
                START: if (!bus.spi_busy) begin
                    bus.spi_start   <= 1'b1;
                    bus.spi_data_in <= bus.tx_data[g*DATA_WIDTH +: DATA_WIDTH];
                    bus.tx_ready    <= NUM_REQ'(1) << g;
                    state           <= WAIT;
                end
                WAIT: if (bus.spi_valid) begin
                    bus.rx_data  <= bus.spi_data_out;
                    bus.rx_valid <= bus.grant;
                    rem          <= rem - 1'b1;
                    if (rem == LEN_WIDTH'(1)) begin
                        cnt   <= CW'(CS_HOLD);
                        state <= HOLD;
                    end else begin
                        state <= START;
                    end
                end
                HOLD: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        bus.cs_n  <= '1;
                        bus.grant <= '0;
                        bus.done  <= bus.grant;
                        ptr       <= g == IW'(NUM_REQ - 1) ? '0 : g + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
